// File: rtl/rl11_dma.sv
// rtl/rl11_dma.sv - RL01/02 Unibus NPR DMA sequencer with ARM-side 256-word sector buffer
// Optional burst tenures: define RL11_DMA_BURST_EN (BURST words per bus tenure).
module rl11_dma #(
  parameter int unsigned SETUPCYC = 8,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned BURST    = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic        armintrq,
  input  logic        init_in_h,
  input  logic        npg_in_h,
  input  logic        bbsy_in_h,
  input  logic        ssyn_in_h,
  input  logic [15:0] d_in_h,
  output logic        npr_out_h,
  output logic        sack_out_h,
  output logic        bbsy_out_h,
  output logic        msyn_out_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h
);

  localparam logic [31:0] IDENT = 32'h444D1004;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAITBUS, S_SETUP, S_WAITSSYN, S_HOLD, S_RELEASE
  } state_t;

  state_t      r_state;
  logic [15:0] r_buf [0:255];
  logic [15:0] r_dmaq;
  logic [15:0] r_armq;
  logic [7:0]  r_ptr;
  logic [7:0]  r_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_nxm;
  logic        r_dir;
  logic [8:0]  r_remaining;
  logic [17:0] r_addr;
  logic [31:0] r_cnt;
  logic        r_ctl_dir;
  logic [7:0]  r_ctl_cnt;
  logic [31:0] r_armreg;
  logic [2:0]  r_rsel;
  logic        r_npr;
  logic        r_sack;
  logic        r_bbsy;
  logic        r_msyn;
  logic [17:0] r_a;
  logic [1:0]  r_c;
  logic [15:0] r_d;

  logic        w_wr_ctl;
  logic        w_go;
  logic        w_wr_addr;
  logic        w_wr_data;
  logic        w_wr_ptr;
  logic        w_rd_data;
  logic        w_abort;
  logic        w_dma_wr;
  logic        w_last;
  logic        w_stay;
  logic [7:0]  w_ridx;
  logic        w_unused;

  // The ARM bridge has no read strobe: each cycle register 3 is addressed
  // without a write counts as one read access and advances the pointer.
  assign w_wr_ctl  = armwrite && (armwaddr == 3'd1);
  assign w_go      = w_wr_ctl && armwdata[31];
  assign w_wr_addr = armwrite && (armwaddr == 3'd2);
  assign w_wr_data = armwrite && (armwaddr == 3'd3);
  assign w_wr_ptr  = armwrite && (armwaddr == 3'd4);
  assign w_rd_data = !armwrite && (armraddr == 3'd3);

  assign w_abort  = init_in_h && (r_state != S_IDLE);
  assign w_dma_wr = !RESET && !init_in_h && (r_state == S_WAITSSYN) && ssyn_in_h && !r_dir;
  assign w_last   = (r_remaining == 9'd1);

  // Prefetch the next DMA word as soon as the index advances so it is ready
  // when the bus data lines are loaded.
  assign w_ridx = ((r_state == S_WAITSSYN) && ssyn_in_h) ? (r_idx + 8'd1) : r_idx;

`ifdef RL11_DMA_BURST_EN
  logic [31:0] r_tcnt;
  assign w_stay   = (r_tcnt + 32'd1) < BURST;
  assign w_unused = ^armwdata[28:18];
`else
  assign w_stay   = 1'b0;
  assign w_unused = (^armwdata[28:18]) ^ (BURST != 32'd0);
`endif

  // INIT must clear the bus lines in the same cycle, ahead of the registers.
  assign npr_out_h  = r_npr  & ~init_in_h;
  assign sack_out_h = r_sack & ~init_in_h;
  assign bbsy_out_h = r_bbsy & ~init_in_h;
  assign msyn_out_h = r_msyn & ~init_in_h;
  assign a_out_h    = init_in_h ? 18'h0 : r_a;
  assign c_out_h    = init_in_h ? 2'b00 : r_c;
  assign d_out_h    = init_in_h ? 16'h0 : r_d;
  assign armintrq   = r_done;
  assign armrdata   = (r_rsel == 3'd3) ? {16'h0, r_armq} : r_armreg;

  // Sector buffer RAM: a DATI capture wins over an ARM store in the same cycle.
  always_ff @(posedge CLOCK) begin
    if (w_dma_wr) begin
      r_buf[r_idx] <= d_in_h;
    end else if (w_wr_data && !RESET) begin
      r_buf[r_ptr] <= armwdata[15:0];
    end
    r_dmaq <= r_buf[w_ridx];
    r_armq <= r_buf[r_ptr];
  end

  // Registered ARM read mux; register 3 comes from the RAM read port.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_rsel   <= 3'd0;
      r_armreg <= 32'h0;
    end else begin
      r_rsel <= armraddr;
      case (armraddr)
        3'd0:    r_armreg <= IDENT;
        3'd1:    r_armreg <= {1'b0, r_ctl_dir, 22'h0, r_ctl_cnt};
        3'd2:    r_armreg <= {14'h0, r_addr};
        3'd4:    r_armreg <= {r_busy, r_done, r_nxm, 13'h0, r_remaining[7:0], r_ptr};
        default: r_armreg <= 32'h0;
      endcase
    end
  end

  // ARM register writes plus the NPR bus sequencer with registered bus outputs.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_ptr       <= 8'd0;
      r_idx       <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_nxm       <= 1'b0;
      r_dir       <= 1'b0;
      r_remaining <= 9'd0;
      r_addr      <= 18'h0;
      r_cnt       <= 32'd0;
      r_ctl_dir   <= 1'b0;
      r_ctl_cnt   <= 8'd0;
      r_npr       <= 1'b0;
      r_sack      <= 1'b0;
      r_bbsy      <= 1'b0;
      r_msyn      <= 1'b0;
      r_a         <= 18'h0;
      r_c         <= 2'b00;
      r_d         <= 16'h0;
`ifdef RL11_DMA_BURST_EN
      r_tcnt      <= 32'd0;
`endif
    end else begin
      if (w_wr_ptr) begin
        r_ptr <= armwdata[7:0];
      end else if (w_wr_data || w_rd_data) begin
        r_ptr <= r_ptr + 8'd1;
      end
      if (w_wr_ctl && armwdata[29]) begin
        r_done <= 1'b0;
        r_nxm  <= 1'b0;
      end
      if (w_wr_ctl && (r_state == S_IDLE)) begin
        r_ctl_dir <= armwdata[30];
        r_ctl_cnt <= armwdata[7:0];
      end
      if (w_wr_addr && (r_state == S_IDLE)) begin
        r_addr <= {armwdata[17:1], 1'b0};
      end

      if (w_abort) begin
        r_npr   <= 1'b0;
        r_sack  <= 1'b0;
        r_bbsy  <= 1'b0;
        r_msyn  <= 1'b0;
        r_a     <= 18'h0;
        r_c     <= 2'b00;
        r_d     <= 16'h0;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_nxm   <= 1'b1;
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_go) begin
              r_dir       <= armwdata[30];
              r_remaining <= (armwdata[7:0] == 8'd0) ? 9'd256 : {1'b0, armwdata[7:0]};
              r_idx       <= 8'd0;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
              r_nxm       <= 1'b0;
              r_npr       <= 1'b1;
              r_state     <= S_REQ;
            end
          end
          S_REQ: begin
            if (npg_in_h) begin
              r_sack  <= 1'b1;
              r_npr   <= 1'b0;
              r_state <= S_WAITBUS;
            end
          end
          S_WAITBUS: begin
            if (!npg_in_h && !bbsy_in_h && !ssyn_in_h) begin
              r_bbsy  <= 1'b1;
              r_sack  <= 1'b0;
              r_a     <= r_addr;
              r_c     <= r_dir ? 2'b10 : 2'b00;
              r_d     <= r_dir ? r_dmaq : 16'h0;
              r_cnt   <= 32'd0;
`ifdef RL11_DMA_BURST_EN
              r_tcnt  <= 32'd0;
`endif
              r_state <= S_SETUP;
            end
          end
          S_SETUP: begin
            if (r_cnt == SETUPCYC - 1) begin
              r_msyn  <= 1'b1;
              r_cnt   <= 32'd0;
              r_state <= S_WAITSSYN;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          S_WAITSSYN: begin
            if (ssyn_in_h) begin
              r_msyn  <= 1'b0;
              r_idx   <= r_idx + 8'd1;
              r_cnt   <= 32'd0;
              r_state <= S_HOLD;
            end else if (r_cnt == TIMEOUT - 1) begin
              r_nxm   <= 1'b1;
              r_msyn  <= 1'b0;
              r_bbsy  <= 1'b0;
              r_a     <= 18'h0;
              r_c     <= 2'b00;
              r_d     <= 16'h0;
              r_state <= S_RELEASE;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          S_HOLD: begin
            if (ssyn_in_h) begin
              r_cnt <= 32'd0;
            end else if (r_cnt == SETUPCYC - 1) begin
              r_cnt       <= 32'd0;
              r_remaining <= r_remaining - 9'd1;
              r_addr      <= r_addr + 18'd2;
              if (!w_last && w_stay) begin
                r_a     <= r_addr + 18'd2;
                r_d     <= r_dir ? r_dmaq : 16'h0;
`ifdef RL11_DMA_BURST_EN
                r_tcnt  <= r_tcnt + 32'd1;
`endif
                r_state <= S_SETUP;
              end else begin
                r_bbsy  <= 1'b0;
                r_a     <= 18'h0;
                r_c     <= 2'b00;
                r_d     <= 16'h0;
                r_state <= S_RELEASE;
              end
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          S_RELEASE: begin
            r_bbsy <= 1'b0;
            r_a    <= 18'h0;
            r_c    <= 2'b00;
            r_d    <= 16'h0;
            if ((r_remaining != 9'd0) && !r_nxm) begin
              r_npr   <= 1'b1;
              r_state <= S_REQ;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/rl11_dma.md
# rl11_dma

DMA sequencer for the RL01/02 disk path. The ARM side loads a 256-word sector buffer plus a transfer descriptor (18-bit bus address, word count, direction). The block then arbitrates for the PDP-11 Unibus as an NPR master and moves the words between the buffer and PDP memory with MSYN/SSYN cycles. Completion and NXM status go back to the ARM, replacing per-word software bus cycles in the RL driver.

## Interface
Parameters:
- SETUPCYC, 8: CLOCK cycles address/data/control are held before MSYN is asserted, and after it is dropped.
- TIMEOUT, 1000: CLOCK cycles to wait for SSYN before flagging NXM.
- BURST, 4: maximum words per bus tenure (used only with the burst option).

Ports:
- CLOCK in 1: system clock.
- RESET in 1: synchronous, active-high.
- armwrite in 1: ARM register write strobe.
- armraddr, armwaddr in 3 each: ARM register read/write index.
- armwdata in 32: ARM write data.
- armrdata out 32: ARM read data.
- armintrq out 1: level, high while the done flag is set.
- init_in_h in 1: Unibus INIT.
- npg_in_h in 1: NPR grant.
- bbsy_in_h in 1: Unibus busy.
- ssyn_in_h in 1: slave sync.
- d_in_h in 16: Unibus data in.
- npr_out_h out 1: NPR request.
- sack_out_h out 1: selection acknowledge.
- bbsy_out_h out 1: this block holds the bus.
- msyn_out_h out 1: master sync.
- a_out_h out 18: bus address.
- c_out_h out 2: bus control.
- d_out_h out 16: bus data out.

## Operation
ARM registers:
- 0: ident 32'h444D1004.
- 1 control:
  - [31] go (write-only pulse).
  - [30] dir: 1 = buffer→memory (DATO, c=2'b10); 0 = memory→buffer (DATI, c=2'b00).
  - [7:0] word count; 0 means 256.
- 2: [17:0] bus address; bit 0 is forced 0.
- 3: buffer data. Write stores [15:0] at the buffer pointer; read returns the word at the pointer. Both auto-increment the pointer (8 bits, wraps 255→0).
- 4: [7:0] writes the buffer pointer. Reads return {busy[31], done[30], nxm[29], 13'b0, remaining[15:8], pointer[7:0]}.
- Writing control with bit 29 set clears done and nxm.

DMA runs from buffer word 0. Go is ignored while busy. Register 2 reads the live address, which increments by 2 each word and wraps mod 2^18.

States:
- IDLE: on go, latch the descriptor, set busy, clear done and nxm → REQ.
- REQ: npr_out_h=1. When npg_in_h=1, set sack_out_h=1 and drop npr_out_h → WAITBUS.
- WAITBUS: once npg_in_h=0, bbsy_in_h=0 and ssyn_in_h=0, set bbsy_out_h=1, drop sack_out_h and drive a/c/d → SETUP.
- SETUP: count SETUPCYC cycles, then msyn_out_h=1 → WAITSSYN.
- WAITSSYN:
  - On ssyn_in_h=1, capture d_in_h into the buffer on DATI, then msyn_out_h=0 → HOLD.
  - After TIMEOUT cycles with no SSYN, set nxm, msyn_out_h=0 → RELEASE.
- HOLD: wait for ssyn_in_h=0 plus SETUPCYC cycles. Decrement remaining and advance the address and index.
  - remaining=0 → RELEASE.
  - Otherwise → RELEASE (no burst build) or SETUP (burst build, see Configuration).
- RELEASE: drop bbsy_out_h and tristate-equivalent zero a/c/d.
  - Remaining>0 and not nxm → REQ.
  - Otherwise clear busy, set done → IDLE.

Boundary rules:
- init_in_h mid-transfer: all bus outputs go to 0 the same cycle; abort to IDLE with done=1, nxm=1. Buffer contents are kept.
- RESET additionally clears the buffer pointer and all flags; buffer RAM is not cleared.
- ARM buffer writes while busy are accepted. Bench result is undefined for the word being transferred; the software rule is no writes while busy.

## Timing
- Reset values: npr/sack/bbsy/msyn = 0; a_out_h, c_out_h, d_out_h = 0; armintrq = 0; busy/done/nxm = 0.
- go → npr_out_h high: 1 cycle.
- Grant → sack: 1 cycle.
- Address stable ≥ SETUPCYC cycles before msyn rises.
- msyn falls 1 cycle after ssyn is seen.
- A non-burst word with an instant slave takes ≈ 2·SETUPCYC + 6 cycles plus arbitration.
- done and armintrq rise together, 1 cycle after the final bbsy drop.
- Buffer is single-clock synchronous RAM. ARM read of register 3 returns data registered from the pointer prior to the access.

## Configuration
- RL11_DMA_BURST_EN defined: after HOLD, if remaining>0 and fewer than BURST words have moved this tenure, go straight to SETUP keeping bbsy_out_h.
- Undefined: the bus is released and re-requested after every word, and BURST is ignored.

## Test plan
- DATO, 3 words from address 18'o001000 with an instant-SSYN memory model → memory 001000/001002/001004 hold buffer words 0–2; done=1, nxm=0; register 2 reads 18'o001006.
- DATI, count 0 → 256 words read into the buffer; remaining=0; without the burst option, 256 NPR tenures are counted.
- DATO to 18'o760000 with no responder → after TIMEOUT cycles nxm=1, done=1, bbsy_out_h=0; only 1 msyn pulse.
- Address 18'o777776, 2 words → second cycle addresses 18'o000000.
- init_in_h asserted during WAITSSYN → msyn/bbsy drop the same cycle; done=1, nxm=1.
- With RL11_DMA_BURST_EN and BURST=4, a 10-word transfer → exactly 3 bbsy tenures (4, 4, 2 words).
